// File: rtl/leaf_stream_buffer_pkg.sv
// Shared definitions for leaf_stream_buffer and its FIFO sub-module.
//   PAYLOAD_BITS_DEF : default data width per channel
//   MAX_PORTS        : largest supported ingress/egress channel count
//   ptr_width()      : FIFO pointer width; the extra MSB separates full from empty
//   start_state_e    : start-gate states
package leaf_pkg;

  localparam int unsigned PAYLOAD_BITS_DEF = 32;
  localparam int unsigned MAX_PORTS        = 15;

  function automatic int unsigned ptr_width(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } start_state_e;

endpackage

// File: rtl/leaf_stream_buffer_if.sv
// Handshake bundle for leaf_stream_buffer.
//   if_in_*   : interface -> buffer ingress (data/vld in, ack out)
//   usr_in_*  : buffer -> kernel ingress heads (data/vld out, ack in)
//   usr_out_* : kernel -> buffer egress (data/vld in, ack out)
//   if_out_*  : buffer -> interface egress heads (data/vld out, ack in)
// Channel i occupies data bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
// Modport slave is the buffer side; master is the surrounding environment.
interface leaf_stream_buffer_if #(
  parameter int unsigned PAYLOAD_BITS  = leaf_pkg::PAYLOAD_BITS_DEF,
  parameter int unsigned NUM_IN_PORTS  = 2,
  parameter int unsigned NUM_OUT_PORTS = 1
);

  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  if_in_data;
  logic [NUM_IN_PORTS-1:0]               if_in_vld;
  logic [NUM_IN_PORTS-1:0]               if_in_ack;

  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  usr_in_data;
  logic [NUM_IN_PORTS-1:0]               usr_in_vld;
  logic [NUM_IN_PORTS-1:0]               usr_in_ack;

  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] usr_out_data;
  logic [NUM_OUT_PORTS-1:0]              usr_out_vld;
  logic [NUM_OUT_PORTS-1:0]              usr_out_ack;

  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_out_data;
  logic [NUM_OUT_PORTS-1:0]              if_out_vld;
  logic [NUM_OUT_PORTS-1:0]              if_out_ack;

  modport slave (
    input  if_in_data, if_in_vld,
    output if_in_ack,
    output usr_in_data, usr_in_vld,
    input  usr_in_ack,
    input  usr_out_data, usr_out_vld,
    output usr_out_ack,
    output if_out_data, if_out_vld,
    input  if_out_ack
  );

  modport master (
    output if_in_data, if_in_vld,
    input  if_in_ack,
    input  usr_in_data, usr_in_vld,
    output usr_in_ack,
    output usr_out_data, usr_out_vld,
    input  usr_out_ack,
    input  if_out_data, if_out_vld,
    output if_out_ack
  );

endinterface

// File: rtl/leaf_stream_buffer_fifo.sv
// leaf_chan_fifo: one first-word-fall-through channel FIFO of 2^DEPTH_LOG2 entries.
//   clk, reset          : clock, synchronous active-high reset
//   wr_data_i/wr_vld_i  : producer word and valid
//   wr_ack_o            : not full (low during and until the first edge after reset)
//   rd_data_o/rd_vld_o  : head word and not-empty
//   rd_ack_i            : consumer takes the head (ignored while empty)
module leaf_chan_fifo
  import leaf_pkg::*;
#(
  parameter int unsigned WIDTH      = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_vld_i,
  output logic             wr_ack_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_vld_o,
  input  logic             rd_ack_i
);

  localparam int unsigned PW    = ptr_width(DEPTH_LOG2);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic             rdy_q;
  logic             full, empty, push, pop;

  // Same slot index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) &&
                 (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
  assign empty = (wr_q == rd_q);

  // rdy_q holds ack low through reset and releases it on the first edge after.
  assign wr_ack_o  = rdy_q & ~full;
  assign rd_vld_o  = ~empty;
  assign rd_data_o = mem_q[rd_q[DEPTH_LOG2-1:0]];

  assign push = wr_vld_i & wr_ack_o;
  assign pop  = rd_ack_i & rd_vld_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      rdy_q <= 1'b1;
    end
  end

  // Storage is not reset; clearing the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/leaf_stream_buffer.sv
// leaf_stream_buffer: per-channel FIFO buffering between leaf_interface and an
// HLS kernel, plus a registered gate on the kernel's ap_start.
//   clk, reset    : single clock, synchronous active-high reset
//   ap_start      : start request from the leaf wrapper
//   ap_start_out  : gated start to the kernel (high once RUN is entered)
//   bus           : leaf_stream_buffer_if.slave carrying all channel handshakes
// Optional (macro LEAF_STREAM_BUFFER_STATS_EN):
//   in_word_cnt   : NUM_IN_PORTS x 32-bit counts of usr_in pops
//   out_word_cnt  : NUM_OUT_PORTS x 32-bit counts of if_out pops
//   out_hwm       : NUM_OUT_PORTS x (DEPTH_LOG2+1)-bit peak egress occupancy
module leaf_stream_buffer
  import leaf_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
  parameter int unsigned NUM_IN_PORTS  = 2,
  parameter int unsigned NUM_OUT_PORTS = 1,
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned START_ON_DATA = 0,
  localparam int unsigned PW           = ptr_width(DEPTH_LOG2)
) (
  input  logic clk,
  input  logic reset,
  input  logic ap_start,
  output logic ap_start_out,
  leaf_stream_buffer_if.slave bus
`ifdef LEAF_STREAM_BUFFER_STATS_EN
  ,
  output logic [NUM_IN_PORTS*32-1:0]  in_word_cnt,
  output logic [NUM_OUT_PORTS*32-1:0] out_word_cnt,
  output logic [NUM_OUT_PORTS*PW-1:0] out_hwm
`endif
);

  logic [NUM_IN_PORTS-1:0]               if_in_ack;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  usr_in_data;
  logic [NUM_IN_PORTS-1:0]               usr_in_vld;
  logic [NUM_OUT_PORTS-1:0]              usr_out_ack;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_out_data;
  logic [NUM_OUT_PORTS-1:0]              if_out_vld;

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    leaf_chan_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_data_i (bus.if_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld_i  (bus.if_in_vld[i]),
      .wr_ack_o  (if_in_ack[i]),
      .rd_data_o (usr_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld_o  (usr_in_vld[i]),
      .rd_ack_i  (bus.usr_in_ack[i])
    );
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    leaf_chan_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_data_i (bus.usr_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld_i  (bus.usr_out_vld[j]),
      .wr_ack_o  (usr_out_ack[j]),
      .rd_data_o (if_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld_o  (if_out_vld[j]),
      .rd_ack_i  (bus.if_out_ack[j])
    );
  end

  assign bus.if_in_ack   = if_in_ack;
  assign bus.usr_in_data = usr_in_data;
  assign bus.usr_in_vld  = usr_in_vld;
  assign bus.usr_out_ack = usr_out_ack;
  assign bus.if_out_data = if_out_data;
  assign bus.if_out_vld  = if_out_vld;

  // Start gate: once RUN is reached only reset returns it to IDLE.
  start_state_e state_q, state_d;
  logic         start_ok;

  always_comb begin
    start_ok = ap_start;
    if (START_ON_DATA != 0) start_ok = ap_start & (&usr_in_vld);
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign ap_start_out = (state_q == RUN);

`ifdef LEAF_STREAM_BUFFER_STATS_EN
  logic [NUM_IN_PORTS*32-1:0]  in_cnt_q, in_cnt_d;
  logic [NUM_OUT_PORTS*32-1:0] out_cnt_q, out_cnt_d;
  logic [NUM_OUT_PORTS*PW-1:0] occ_q, occ_d;
  logic [NUM_OUT_PORTS*PW-1:0] hwm_q, hwm_d;
  logic [PW-1:0]               occ;
  logic                        o_push, o_pop;

  // Egress occupancy is shadowed here from the handshakes rather than read
  // out of the FIFOs, so the FIFO stays identical in both builds.
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    occ_d     = occ_q;
    hwm_d     = hwm_q;
    occ       = '0;
    o_push    = 1'b0;
    o_pop     = 1'b0;
    for (int unsigned c = 0; c < NUM_IN_PORTS; c++) begin
      if (usr_in_vld[c] & bus.usr_in_ack[c])
        in_cnt_d[c*32 +: 32] = in_cnt_q[c*32 +: 32] + 32'd1;
    end
    for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
      o_push = bus.usr_out_vld[c] & usr_out_ack[c];
      o_pop  = if_out_vld[c] & bus.if_out_ack[c];
      occ    = occ_q[c*PW +: PW];
      if (o_push & ~o_pop) occ = occ + PW'(1);
      if (o_pop & ~o_push) occ = occ - PW'(1);
      occ_d[c*PW +: PW] = occ;
      if (occ > hwm_q[c*PW +: PW]) hwm_d[c*PW +: PW] = occ;
      if (o_pop) out_cnt_d[c*32 +: 32] = out_cnt_q[c*32 +: 32] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      occ_q     <= '0;
      hwm_q     <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      occ_q     <= occ_d;
      hwm_q     <= hwm_d;
    end
  end

  assign in_word_cnt  = in_cnt_q;
  assign out_word_cnt = out_cnt_q;
  assign out_hwm      = hwm_q;
`endif

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed bench for leaf_stream_buffer: main instance with START_ON_DATA = 0,
// second instance with START_ON_DATA = 1 for the data-gated start.
module tb_leaf_stream_buffer;

  logic clk = 1'b0;
  logic reset;
  logic ap_start, ap_start_out;
  logic ap_start2, ap_start_out2;

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  leaf_stream_buffer_if #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1)) bus ();
  leaf_stream_buffer_if #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1)) bus2 ();

`ifdef LEAF_STREAM_BUFFER_STATS_EN
  logic [63:0] in_word_cnt, in_word_cnt2;
  logic [31:0] out_word_cnt, out_word_cnt2;
  logic [4:0]  out_hwm, out_hwm2;
`endif

  leaf_stream_buffer #(
    .PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1),
    .DEPTH_LOG2(4), .START_ON_DATA(0)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_start_out(ap_start_out),
    .bus(bus)
`ifdef LEAF_STREAM_BUFFER_STATS_EN
    , .in_word_cnt(in_word_cnt), .out_word_cnt(out_word_cnt), .out_hwm(out_hwm)
`endif
  );

  leaf_stream_buffer #(
    .PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1),
    .DEPTH_LOG2(4), .START_ON_DATA(1)
  ) dut2 (
    .clk(clk), .reset(reset), .ap_start(ap_start2), .ap_start_out(ap_start_out2),
    .bus(bus2)
`ifdef LEAF_STREAM_BUFFER_STATS_EN
    , .in_word_cnt(in_word_cnt2), .out_word_cnt(out_word_cnt2), .out_hwm(out_hwm2)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        in_vld;
    logic [31:0] in_data;
    logic        usr_ack;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic        exp_ack;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Ingress channel 0: inputs applied this cycle, outputs expected this cycle.
    tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,         1'b1};
    tbl[1] = '{1'b1, 32'hA5A5_0002, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b1};
    tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0002, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0003, 1'b1, 1'b0, 32'h0,         1'b1};
    tbl[5] = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0003, 1'b1};
    tbl[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 1'b1};
    tbl[7] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b1};
    tbl[8] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1};

    reset = 1'b1; ap_start = 1'b0; ap_start2 = 1'b0;
    bus.if_in_data = '0;  bus.if_in_vld = '0;  bus.usr_in_ack = '0;
    bus.usr_out_data = '0; bus.usr_out_vld = '0; bus.if_out_ack = '0;
    bus2.if_in_data = '0; bus2.if_in_vld = '0; bus2.usr_in_ack = '0;
    bus2.usr_out_data = '0; bus2.usr_out_vld = '0; bus2.if_out_ack = '0;

    // Reset state
    tick; tick;
    chk("rst usr_in_vld", 64'(bus.usr_in_vld), 64'h0);
    chk("rst if_in_ack", 64'(bus.if_in_ack), 64'h0);
    chk("rst usr_out_ack", 64'(bus.usr_out_ack), 64'h0);
    chk("rst if_out_vld", 64'(bus.if_out_vld), 64'h0);
    chk("rst ap_start_out", 64'(ap_start_out), 64'h0);
    reset = 1'b0;
    tick;
    chk("post-rst if_in_ack", 64'(bus.if_in_ack), 64'h3);
    chk("post-rst usr_out_ack", 64'(bus.usr_out_ack), 64'h1);

    // Table-driven ingress channel 0
    for (int k = 0; k < 9; k++) begin
      bus.if_in_vld[0]      = tbl[k].in_vld;
      bus.if_in_data[31:0]  = tbl[k].in_data;
      bus.usr_in_ack[0]     = tbl[k].usr_ack;
      #1;
      chk($sformatf("vec%0d usr_in_vld", k), 64'(bus.usr_in_vld[0]), 64'(tbl[k].exp_vld));
      if (tbl[k].exp_vld)
        chk($sformatf("vec%0d usr_in_data", k), 64'(bus.usr_in_data[31:0]), 64'(tbl[k].exp_data));
      chk($sformatf("vec%0d if_in_ack", k), 64'(bus.if_in_ack[0]), 64'(tbl[k].exp_ack));
      tick;
    end
    bus.if_in_vld = '0; bus.usr_in_ack = '0;

    // Start gate without data dependency; dropping ap_start has no effect
    chk("start idle", 64'(ap_start_out), 64'h0);
    ap_start = 1'b1;
    tick;
    chk("start run", 64'(ap_start_out), 64'h1);
    ap_start = 1'b0;
    tick; tick; tick;
    chk("start sticky", 64'(ap_start_out), 64'h1);

    // Streaming at occupancy 5 on ingress channel 1 (wraps pointers)
    for (int k = 0; k < 5; k++) begin
      bus.if_in_vld[1] = 1'b1; bus.if_in_data[63:32] = 32'(100 + k);
      tick;
    end
    for (int k = 0; k < 100; k++) begin
      bus.if_in_vld[1] = 1'b1; bus.if_in_data[63:32] = 32'(105 + k);
      bus.usr_in_ack[1] = 1'b1;
      #1;
      chk($sformatf("stream%0d vld", k), 64'(bus.usr_in_vld[1]), 64'h1);
      chk($sformatf("stream%0d data", k), 64'(bus.usr_in_data[63:32]), 64'(100 + k));
      tick;
    end
    bus.if_in_vld[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.usr_in_ack[1] = 1'b1;
      #1;
      chk($sformatf("drain%0d vld", k), 64'(bus.usr_in_vld[1]), 64'h1);
      chk($sformatf("drain%0d data", k), 64'(bus.usr_in_data[63:32]), 64'(200 + k));
      tick;
    end
    bus.usr_in_ack[1] = 1'b0;
    #1;
    chk("stream empty", 64'(bus.usr_in_vld[1]), 64'h0);

    // Egress fill to full, push attempt while full, single pop, ordered drain
    bus.if_out_ack = '0;
    for (int k = 0; k < 16; k++) begin
      bus.usr_out_vld[0] = 1'b1; bus.usr_out_data = 32'(k);
      #1;
      chk($sformatf("fill%0d ack", k), 64'(bus.usr_out_ack[0]), 64'h1);
      tick;
    end
    bus.usr_out_data = 32'h99;
    #1;
    chk("full ack", 64'(bus.usr_out_ack[0]), 64'h0);
    tick;
    bus.usr_out_vld[0] = 1'b0;
    chk("full ack held", 64'(bus.usr_out_ack[0]), 64'h0);
    chk("full head", 64'(bus.if_out_data), 64'h0);
    bus.if_out_ack[0] = 1'b1;
    #1;
    chk("full pop no bypass", 64'(bus.usr_out_ack[0]), 64'h0);
    tick;
    bus.if_out_ack[0] = 1'b0;
    chk("ack after pop", 64'(bus.usr_out_ack[0]), 64'h1);
    for (int k = 1; k < 16; k++) begin
      bus.if_out_ack[0] = 1'b1;
      #1;
      chk($sformatf("egress%0d vld", k), 64'(bus.if_out_vld[0]), 64'h1);
      chk($sformatf("egress%0d data", k), 64'(bus.if_out_data), 64'(k));
      tick;
    end
    bus.if_out_ack[0] = 1'b0;
    #1;
    chk("egress empty", 64'(bus.if_out_vld[0]), 64'h0);

    // Reset with 7 words buffered on ingress channel 0
    for (int k = 0; k < 7; k++) begin
      bus.if_in_vld[0] = 1'b1; bus.if_in_data[31:0] = 32'(k);
      tick;
    end
    bus.if_in_vld[0] = 1'b0;
    chk("pre-rst vld", 64'(bus.usr_in_vld[0]), 64'h1);
    reset = 1'b1;
    tick;
    chk("mid-rst usr_in_vld", 64'(bus.usr_in_vld), 64'h0);
    chk("mid-rst if_in_ack", 64'(bus.if_in_ack), 64'h0);
    chk("mid-rst usr_out_ack", 64'(bus.usr_out_ack), 64'h0);
    chk("mid-rst if_out_vld", 64'(bus.if_out_vld), 64'h0);
    chk("mid-rst ap_start_out", 64'(ap_start_out), 64'h0);
    reset = 1'b0;
    tick;
    chk("after-rst if_in_ack", 64'(bus.if_in_ack), 64'h3);
    chk("after-rst usr_out_ack", 64'(bus.usr_out_ack), 64'h1);
    chk("after-rst usr_in_vld", 64'(bus.usr_in_vld), 64'h0);
    chk("after-rst ap_start_out", 64'(ap_start_out), 64'h0);
    tick;
    chk("after-rst still empty", 64'(bus.usr_in_vld), 64'h0);

`ifdef LEAF_STREAM_BUFFER_STATS_EN
    chk("stats cleared", in_word_cnt, 64'h0);
    for (int k = 0; k < 37; k++) begin
      bus.if_in_vld[1] = 1'b1; bus.if_in_data[63:32] = 32'(k);
      tick;
      bus.if_in_vld[1] = 1'b0; bus.usr_in_ack[1] = 1'b1;
      tick;
      bus.usr_in_ack[1] = 1'b0;
    end
    chk("in_word_cnt[1]", 64'(in_word_cnt[63:32]), 64'd37);
    chk("in_word_cnt[0]", 64'(in_word_cnt[31:0]), 64'd0);
    for (int k = 0; k < 9; k++) begin
      bus.usr_out_vld[0] = 1'b1; bus.usr_out_data = 32'(k);
      tick;
    end
    bus.usr_out_vld[0] = 1'b0;
    chk("out_hwm 9", 64'(out_hwm), 64'd9);
    bus.if_out_ack[0] = 1'b1;
    tick; tick; tick;
    bus.if_out_ack[0] = 1'b0;
    bus.usr_out_vld[0] = 1'b1;
    tick; tick;
    bus.usr_out_vld[0] = 1'b0;
    chk("out_hwm sticky", 64'(out_hwm), 64'd9);
    chk("out_word_cnt", 64'(out_word_cnt), 64'd3);
`endif

    // Data-gated start on the second instance
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    chk("sod idle", 64'(ap_start_out2), 64'h0);
    ap_start2 = 1'b1;
    bus2.if_in_vld[0] = 1'b1; bus2.if_in_data[31:0] = 32'hC0;
    tick;
    bus2.if_in_vld[0] = 1'b0;
    tick; tick;
    chk("sod ch1 empty", 64'(ap_start_out2), 64'h0);
    bus2.if_in_vld[1] = 1'b1; bus2.if_in_data[63:32] = 32'hC1;
    tick;
    bus2.if_in_vld[1] = 1'b0;
    chk("sod vld seen", 64'(bus2.usr_in_vld), 64'h3);
    chk("sod not yet", 64'(ap_start_out2), 64'h0);
    tick;
    chk("sod run", 64'(ap_start_out2), 64'h1);
    ap_start2 = 1'b0;
    tick; tick;
    chk("sod sticky", 64'(ap_start_out2), 64'h1);
`ifdef LEAF_STREAM_BUFFER_STATS_EN
    chk("sod in_word_cnt", in_word_cnt2, 64'h0);
    chk("sod out_word_cnt", 64'(out_word_cnt2), 64'h0);
    chk("sod out_hwm", 64'(out_hwm2), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/leaf_stream_buffer.md
Name: leaf_stream_buffer

Overview:
Parametrised per-channel buffering stage between leaf_interface and an HLS user kernel inside a leaf wrapper.
- Provides NUM_IN_PORTS ingress FIFOs (interface to user) and NUM_OUT_PORTS egress FIFOs (user to interface).
- All ports use ap_vld/ap_ack handshakes.
- Decouples kernel stalls from the BFT interface and gates the kernel's ap_start.
- Replaces direct interface-to-kernel wiring in leaves whose kernels burst or stall.

Parameters:
PAYLOAD_BITS, 32, data width per channel
NUM_IN_PORTS, 2, ingress channel count (1..15)
NUM_OUT_PORTS, 1, egress channel count (1..15)
DEPTH_LOG2, 4, log2 of FIFO depth per channel (depth = 16)
START_ON_DATA, 0, 1 = ap_start_out also waits until every ingress FIFO is non-empty

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
ap_start  in  1  start request from the leaf wrapper
ap_start_out  out  1  gated start to the kernel
if_in_data  in  NUM_IN_PORTS*PAYLOAD_BITS  interface-to-buffer data, channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
if_in_vld  in  NUM_IN_PORTS  per-channel valid
if_in_ack  out  NUM_IN_PORTS  per-channel ack (not full)
usr_in_data  out  NUM_IN_PORTS*PAYLOAD_BITS  FIFO head to kernel
usr_in_vld  out  NUM_IN_PORTS  FIFO non-empty
usr_in_ack  in  NUM_IN_PORTS  kernel consumes head
usr_out_data  in  NUM_OUT_PORTS*PAYLOAD_BITS  kernel output data
usr_out_vld  in  NUM_OUT_PORTS  kernel output valid
usr_out_ack  out  NUM_OUT_PORTS  not full
if_out_data  out  NUM_OUT_PORTS*PAYLOAD_BITS  egress FIFO head to interface
if_out_vld  out  NUM_OUT_PORTS  non-empty
if_out_ack  in  NUM_OUT_PORTS  interface consumes head

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. Transfer occurs on a rising clk edge when vld and ack are both high.
- Every channel is an independent first-word-fall-through FIFO of 2^DEPTH_LOG2 entries.
  - Read/write pointers are DEPTH_LOG2+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2^(DEPTH_LOG2+1).
- ack_out = !full. vld_out = !empty. data_out = mem[rd_ptr] (combinational read of registered storage).
- Latency: a word pushed at edge N is visible with vld high after edge N. Push-to-pop minimum is 1 cycle. There is no combinational vld/data bypass.
- Full:
  - ack is low, so no push occurs.
  - A pop in the same cycle frees one slot; ack rises the following cycle.
  - No full-bypass.
- Empty: vld is low; any ack from the consumer is ignored.
- Simultaneous push and pop when neither full nor empty: both occur and the count is unchanged.
- Reset (any cycle, including mid-transfer):
  - Pointers are cleared and all FIFOs become empty; FIFO contents are discarded.
  - All vld = 0, all ack = 0 during reset; ack = 1 from the first cycle after reset.
  - ap_start_out = 0.
- Start gate: a registered state machine with states IDLE and RUN.
  - IDLE to RUN on ap_start high, and, when START_ON_DATA = 1, all usr_in_vld high.
  - RUN holds until reset. ap_start_out = (state == RUN).
  - ap_start going low after RUN is entered has no effect.

Optional Feature:
Macro LEAF_STREAM_BUFFER_STATS_EN.
- Defined: adds output ports in_word_cnt [NUM_IN_PORTS*32] and out_word_cnt [NUM_OUT_PORTS*32].
  - Per-channel counts of completed consumer-side pops.
  - Counters are cleared by reset and wrap at 2^32.
  - Also adds a sticky out_hwm [NUM_OUT_PORTS*(DEPTH_LOG2+1)] holding the maximum occupancy seen per egress FIFO.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package leaf_pkg: PAYLOAD_BITS default, max port count 15, function for pointer width, state enum {IDLE, RUN}.
- Sub-module leaf_chan_fifo (parameters WIDTH, DEPTH_LOG2) holds one FIFO. It is instantiated in generate loops NUM_IN_PORTS + NUM_OUT_PORTS times.
- The top level contains only the start FSM and the optional stats logic.

Test Plan:
- Reset, then push 0xA5A5_0001 on ingress channel 0 at cycle 3 -> usr_in_vld[0] = 1 at cycle 4 with data 0xA5A5_0001; if_in_ack[0] stays 1.
- Fill egress channel 0 with 16 words while if_out_ack = 0 -> usr_out_ack[0] = 0 after the 16th push. Pop one word -> ack returns the next cycle. Data order is 0..15.
- Push and pop simultaneously every cycle for 100 cycles at occupancy 5 -> occupancy stays 5 and no word is lost or duplicated; pointer wrap is exercised.
- START_ON_DATA = 1: ap_start = 1 with channel 1 empty -> ap_start_out = 0. Push one word into channel 1 -> ap_start_out = 1 on the next cycle. Drop ap_start -> output stays 1.
- Assert reset with 7 words buffered mid-stream -> the next cycle shows all vld = 0, ack = 0, ap_start_out = 0. After deassertion, ack = 1 and the FIFOs are empty.
- With LEAF_STREAM_BUFFER_STATS_EN defined: pop 37 words on ingress channel 1 -> in_word_cnt[1] = 37. Push 9 words into egress before any pop -> out_hwm[0] = 9.
